// File: rtl/ram_line_server.sv
// Backing-memory stage on the RAM side of the cache: serves 64-bit lines as 16-bit beat bursts
// with a programmable access latency between request and response.
module ram_line_server #(
  parameter int ADDR_SIZE     = 13,
  parameter int RAM_WORD_SIZE = 16,
  parameter int LINE_WIDTH    = 64,
  parameter int LATENCY       = 4
) (
  input  logic                     ram_clk,
  input  logic                     ram_rst,
  input  logic [ADDR_SIZE-1:0]     ram_addr,
  input  logic                     ram_rnw,
  input  logic                     ram_avalid,
  input  logic [RAM_WORD_SIZE-1:0] ram_wdata,
  output logic [RAM_WORD_SIZE-1:0] ram_rdata,
  output logic                     ram_rack,
  output logic                     ram_busy,
  output logic                     ram_err
);

  localparam int BEATS = LINE_WIDTH / RAM_WORD_SIZE;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [3:0]    LAT_LAST  = 4'(LATENCY - 1);

  if (LATENCY < 1 || LATENCY > 15) begin : g_latency_check
    $error("ram_line_server: LATENCY must be in 1..15");
  end

  typedef enum logic [2:0] {
    IDLE,
    WR_BEATS,
    WAIT,
    RD_BEATS,
    WR_ACK
  } state_t;

  state_t                    state, state_nxt;
  logic [BW-1:0]             beat, beat_nxt;
  logic [3:0]                lat_cnt, lat_cnt_nxt;
  logic [ADDR_SIZE-1:0]      addr_q;
  logic                      rnw_q;
  logic                      accept;
  logic                      capture;
  logic                      commit;
  logic [BW-1:0]             cap_idx;
  logic [LINE_WIDTH-1:0]     wbuf, line_nxt;
  logic [LINE_WIDTH-1:0]     rd_line;
  logic [RAM_WORD_SIZE-1:0]  rdata_nxt;
  logic                      rack_nxt;

  logic [LINE_WIDTH-1:0] mem [2**ADDR_SIZE];

  assign rd_line = mem[addr_q];

  always_comb begin
    state_nxt   = state;
    beat_nxt    = beat;
    lat_cnt_nxt = lat_cnt;
    accept      = 1'b0;
    capture     = 1'b0;
    commit      = 1'b0;
    cap_idx     = beat;
    case (state)
      IDLE: begin
        cap_idx = '0;
        if (ram_avalid) begin
          accept      = 1'b1;
          lat_cnt_nxt = '0;
          beat_nxt    = '0;
          if (ram_rnw) begin
            state_nxt = WAIT;
          end else begin
            capture   = 1'b1;
            beat_nxt  = BW'(1);
            state_nxt = WR_BEATS;
          end
        end
      end
      WR_BEATS: begin
        capture = 1'b1;
        if (beat == LAST_BEAT) begin
          commit    = 1'b1;
          beat_nxt  = '0;
          state_nxt = WAIT;
        end else begin
          beat_nxt = beat + 1'b1;
        end
      end
      WAIT: begin
        if (lat_cnt == LAT_LAST) begin
          lat_cnt_nxt = '0;
          beat_nxt    = '0;
          state_nxt   = rnw_q ? RD_BEATS : WR_ACK;
        end else begin
          lat_cnt_nxt = lat_cnt + 1'b1;
        end
      end
      RD_BEATS: begin
        if (beat == LAST_BEAT) begin
          beat_nxt  = '0;
          state_nxt = IDLE;
        end else begin
          beat_nxt = beat + 1'b1;
        end
      end
      WR_ACK: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The committed line includes the final beat arriving in the same cycle as the commit.
  always_comb begin
    line_nxt = wbuf;
    if (capture) begin
      line_nxt[cap_idx*RAM_WORD_SIZE +: RAM_WORD_SIZE] = ram_wdata;
    end
  end

  // Outputs are registered from the next state so rack lines up with the beat cycles.
  always_comb begin
    rack_nxt  = (state_nxt == RD_BEATS) || (state_nxt == WR_ACK);
    rdata_nxt = '0;
    if (state_nxt == RD_BEATS) begin
      rdata_nxt = rd_line[beat_nxt*RAM_WORD_SIZE +: RAM_WORD_SIZE];
    end
  end

  always_ff @(posedge ram_clk) begin
    if (ram_rst) begin
      state     <= IDLE;
      beat      <= '0;
      lat_cnt   <= '0;
      addr_q    <= '0;
      rnw_q     <= 1'b0;
      wbuf      <= '0;
      ram_rdata <= '0;
      ram_rack  <= 1'b0;
      ram_busy  <= 1'b0;
      ram_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      lat_cnt   <= lat_cnt_nxt;
      wbuf      <= line_nxt;
      ram_rdata <= rdata_nxt;
      ram_rack  <= rack_nxt;
      ram_busy  <= (state_nxt != IDLE);
      if (accept) begin
        addr_q <= ram_addr;
        rnw_q  <= ram_rnw;
      end
      if (ram_avalid && (state != IDLE)) begin
        ram_err <= 1'b1;
      end
    end
  end

  // Storage has no reset; a reset in the commit cycle suppresses the write.
  always_ff @(posedge ram_clk) begin
    if (commit && !ram_rst) begin
      mem[addr_q] <= line_nxt;
    end
  end

endmodule

// File: tb/tb_ram_line_server.sv
// Bench for ram_line_server: two builds (LATENCY 4 and 1), directed literal checks plus
// randomized transactions compared every cycle against an offset-based transaction model.
module tb_ram_line_server;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int L      = (g == 0) ? 4 : 1;
    localparam int WR_CYC = (g == 0) ? 8 : 5;
    localparam int RD_CYC = (g == 0) ? 5 : 2;

    logic        rst, rnw_i, avalid;
    logic [12:0] addr;
    logic [15:0] wdata, rdata;
    logic        rack, busy, err;
    bit          fin;

    ram_line_server #(
      .ADDR_SIZE(13),
      .RAM_WORD_SIZE(16),
      .LINE_WIDTH(64),
      .LATENCY(L)
    ) dut (
      .ram_clk(clk),
      .ram_rst(rst),
      .ram_addr(addr),
      .ram_rnw(rnw_i),
      .ram_avalid(avalid),
      .ram_wdata(wdata),
      .ram_rdata(rdata),
      .ram_rack(rack),
      .ram_busy(busy),
      .ram_err(err)
    );

    // Model: a transaction is described by its cycle offset from acceptance.
    logic [63:0] mm [int];
    bit          m_act, m_rnw, armed;
    int          m_off, m_addr;
    logic [63:0] m_buf, m_line;
    logic        e_rack, e_busy, e_err;
    logic [15:0] e_rdata;
    bit          e_dknown;

    always @(posedge clk) begin
      if (rst) begin
        m_act = 1'b0; e_rack = 1'b0; e_busy = 1'b0; e_err = 1'b0;
        e_rdata = '0; e_dknown = 1'b1;
      end else begin
        if (m_act && avalid) e_err = 1'b1;
        if (!m_act && avalid) begin
          m_act = 1'b1; m_off = 0; m_rnw = rnw_i; m_addr = int'(addr);
        end
        if (m_act && !m_rnw && m_off <= 3) m_buf[16*m_off +: 16] = wdata;
        if (m_act && !m_rnw && m_off == 3) mm[m_addr] = m_buf;
        if (m_act) begin
          m_off++;
          if (m_off > L + 4) m_act = 1'b0;
        end
        e_busy   = m_act;
        e_rack   = m_act && (m_rnw ? (m_off >= L + 1) : (m_off == L + 4));
        e_rdata  = '0;
        e_dknown = 1'b1;
        if (e_rack && m_rnw) begin
          if (mm.exists(m_addr)) begin
            m_line  = mm[m_addr];
            e_rdata = m_line[16*(m_off-L-1) +: 16];
          end else begin
            e_dknown = 1'b0;
          end
        end
      end
      armed = 1'b1;
    end

    always @(negedge clk) begin
      if (armed) begin
        chk($sformatf("lat%0d_rack", L), 64'(rack), 64'(e_rack));
        chk($sformatf("lat%0d_busy", L), 64'(busy), 64'(e_busy));
        chk($sformatf("lat%0d_err", L), 64'(err), 64'(e_err));
        if (e_dknown) chk($sformatf("lat%0d_rdata", L), 64'(rdata), 64'(e_rdata));
      end
    end

    // One transaction starting in the current cycle; spur/rstc = -1 disables them.
    task automatic run(input bit rw, input logic [12:0] a, input logic [63:0] line,
                       input int spur, input int rstc, input int gap,
                       output int first, output int cnt, output logic [63:0] got);
      first = -1; cnt = 0; got = '0;
      for (int c = 0; c <= L + 4; c++) begin
        avalid = (c == 0) || (c == spur);
        rnw_i  = (c == 0) ? rw : 1'($urandom);
        addr   = (c == 0) ? a : 13'($urandom);
        wdata  = (!rw && c <= 3) ? line[16*c +: 16] : 16'($urandom);
        rst    = (c == rstc);
        if (rack) begin
          if (first < 0) first = c;
          if (cnt < 4) got[16*cnt +: 16] = rdata;
          cnt++;
        end
        @(posedge clk); #1;
      end
      rst = 1'b0; avalid = 1'b0;
      for (int i = 0; i < gap; i++) begin
        wdata = 16'($urandom);
        @(posedge clk); #1;
      end
    endtask

    initial begin
      int f, n;
      logic [63:0] got, line;
      logic [12:0] a;
      bit rw;
      int sp, rc;
      rst = 1'b1; avalid = 1'b0; rnw_i = 1'b0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk($sformatf("lat%0d_reset_rack", L), 64'(rack), 64'd0);
      chk($sformatf("lat%0d_reset_rdata", L), 64'(rdata), 64'd0);
      chk($sformatf("lat%0d_reset_busy", L), 64'(busy), 64'd0);
      chk($sformatf("lat%0d_reset_err", L), 64'(err), 64'd0);

      run(1'b0, 13'h0A5, 64'h4444_3333_2222_1111, -1, -1, 0, f, n, got);
      chk($sformatf("lat%0d_wr_ack_cycle", L), 64'(f), 64'(WR_CYC));
      chk($sformatf("lat%0d_wr_ack_count", L), 64'(n), 64'd1);
      run(1'b1, 13'h0A5, '0, -1, -1, 0, f, n, got);
      chk($sformatf("lat%0d_rd_first_cycle", L), 64'(f), 64'(RD_CYC));
      chk($sformatf("lat%0d_rd_count", L), 64'(n), 64'd4);
      chk($sformatf("lat%0d_rd_line", L), got, 64'h4444_3333_2222_1111);
      chk($sformatf("lat%0d_b2b_err", L), 64'(err), 64'd0);

      run(1'b0, 13'h0000, 64'hDEAD_BEEF_0000_0001, -1, -1, 0, f, n, got);
      run(1'b0, 13'h1FFF, 64'h1357_9BDF_FFFF_FFFE, -1, -1, 0, f, n, got);
      run(1'b1, 13'h0000, '0, -1, -1, 0, f, n, got);
      chk($sformatf("lat%0d_addr_lo", L), got, 64'hDEAD_BEEF_0000_0001);
      run(1'b1, 13'h1FFF, '0, -1, -1, 1, f, n, got);
      chk($sformatf("lat%0d_addr_hi", L), got, 64'h1357_9BDF_FFFF_FFFE);

      run(1'b0, 13'h010, 64'hABCD_0123_4567_89EF, -1, -1, 0, f, n, got);
      run(1'b1, 13'h0A5, '0, 1, -1, 0, f, n, got);
      chk($sformatf("lat%0d_spur_line", L), got, 64'h4444_3333_2222_1111);
      chk($sformatf("lat%0d_spur_count", L), 64'(n), 64'd4);
      chk($sformatf("lat%0d_spur_err", L), 64'(err), 64'd1);
      run(1'b1, 13'h0000, '0, -1, -1, 2, f, n, got);
      chk($sformatf("lat%0d_err_sticky", L), 64'(err), 64'd1);

      run(1'b0, 13'h010, 64'h5555_6666_7777_8888, -1, 2, 0, f, n, got);
      chk($sformatf("lat%0d_abort_rack", L), 64'(n), 64'd0);
      chk($sformatf("lat%0d_abort_err", L), 64'(err), 64'd0);
      run(1'b1, 13'h010, '0, -1, -1, 0, f, n, got);
      chk($sformatf("lat%0d_abort_old_line", L), got, 64'hABCD_0123_4567_89EF);

      for (int i = 0; i < 250; i++) begin
        case ($urandom_range(0, 4))
          0: a = 13'h0000;
          1: a = 13'h1FFF;
          2: a = 13'h0A5;
          3: a = 13'h010;
          default: a = 13'($urandom_range(0, 15));
        endcase
        rw   = 1'($urandom);
        line = {$urandom, $urandom};
        sp   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, L + 4) : -1;
        rc   = ($urandom_range(0, 9) == 0) ? $urandom_range(0, L + 4) : -1;
        if (rc >= 0) sp = -1;
        run(rw, a, line, sp, rc, $urandom_range(0, 2), f, n, got);
      end
      fin = 1'b1;
    end
  end

  initial begin
    for (int t = 0; t < 60000 && !(g_lane[0].fin && g_lane[1].fin); t++) @(posedge clk);
    if (!(g_lane[0].fin && g_lane[1].fin)) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=unfinished required=finished");
    end
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
